// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - job sequencer feeding a row of MAC units for C = A x B
module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic                           hold,
    output logic                           rd_en,
    output logic [ADDR_WIDTH-1:0]          rd_addr,
    input  logic [DATA_WIDTH*ROWS-1:0]     rd_a,
    input  logic [DATA_WIDTH-1:0]          rd_b,
    output logic                           mac_en,
    output logic                           mac_clr,
    output logic [DATA_WIDTH*ROWS-1:0]     mac_a,
    output logic [DATA_WIDTH-1:0]          mac_b,
    input  logic [3*DATA_WIDTH*ROWS-1:0]   mac_c,
    output logic [3*DATA_WIDTH*ROWS-1:0]   result,
    output logic                           result_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FETCH   = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                          state_q;
    state_t                          state_d;
    logic [KW-1:0]                   k_q;
    logic [ADDR_WIDTH-1:0]           base_q;
    logic                            mac_en_q;
    logic [3*DATA_WIDTH*ROWS-1:0]    result_q;
    logic                            result_valid_q;
    logic                            last_col;

    assign last_col = (k_q == KW'(COLS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a hold in FETCH simply parks the sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_FETCH;
            S_FETCH:   if (!hold && last_col) state_d = S_DRAIN;
            S_DRAIN:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath registers: column counter, latched base, mac_en delay, result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q            <= '0;
            base_q         <= '0;
            mac_en_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            mac_en_q <= rd_en;
            if (state_q == S_IDLE && start) begin
                base_q         <= base_addr;
                result_valid_q <= 1'b0;
            end
            if (state_q == S_CLEAR) begin
                k_q <= '0;
            end else if (state_q == S_FETCH && !hold) begin
                k_q <= last_col ? '0 : k_q + 1'b1;
            end
            if (state_q == S_CAPTURE) begin
                result_q       <= mac_c;
                result_valid_q <= 1'b1;
            end
        end
    end

    // Output decode; MAC operands are zero whenever no accumulate is requested
    always_comb begin
        rd_en   = (state_q == S_FETCH) && !hold;
        rd_addr = rd_en ? (base_q + ADDR_WIDTH'(k_q)) : '0;
        mac_clr = (state_q == S_CLEAR);
        busy    = (state_q == S_CLEAR) || (state_q == S_FETCH) ||
                  (state_q == S_DRAIN) || (state_q == S_CAPTURE);
        done    = (state_q == S_DONE);
        mac_en  = mac_en_q;
        mac_a   = mac_en_q ? rd_a : '0;
        mac_b   = mac_en_q ? rd_b : '0;
        result       = result_q;
        result_valid = result_valid_q;
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - directed bench for mac_seq_ctrl with memory and MAC models
module tb_mac_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DUT 1: ROWS=2, COLS=4
    logic        start1, hold1, rd_en1, mac_en1, mac_clr1, rv1, busy1, done1;
    logic [7:0]  base1, rd_addr1, rd_b1, mac_b1;
    logic [15:0] rd_a1, mac_a1;
    logic [47:0] mac_c1, result1;

    // DUT 2: ROWS=2, COLS=1
    logic        start2, hold2, rd_en2, mac_en2, mac_clr2, rv2, busy2, done2;
    logic [7:0]  base2, rd_addr2, rd_b2, mac_b2;
    logic [15:0] rd_a2, mac_a2;
    logic [47:0] mac_c2, result2;

    mac_seq_ctrl #(.DATA_WIDTH(8), .ROWS(2), .COLS(4), .ADDR_WIDTH(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .base_addr(base1), .hold(hold1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_a(rd_a1), .rd_b(rd_b1),
        .mac_en(mac_en1), .mac_clr(mac_clr1), .mac_a(mac_a1), .mac_b(mac_b1),
        .mac_c(mac_c1), .result(result1), .result_valid(rv1), .busy(busy1), .done(done1)
    );

    mac_seq_ctrl #(.DATA_WIDTH(8), .ROWS(2), .COLS(1), .ADDR_WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .base_addr(base2), .hold(hold2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_a(rd_a2), .rd_b(rd_b2),
        .mac_en(mac_en2), .mac_clr(mac_clr2), .mac_a(mac_a2), .mac_b(mac_b2),
        .mac_c(mac_c2), .result(result2), .result_valid(rv2), .busy(busy2), .done(done2)
    );

    // Shared operand memory, 1-cycle read latency
    logic [7:0] mem_a0 [256];
    logic [7:0] mem_a1 [256];
    logic [7:0] mem_b  [256];

    always @(posedge clk) begin
        if (rd_en1) begin
            rd_a1 <= {mem_a1[rd_addr1], mem_a0[rd_addr1]};
            rd_b1 <= mem_b[rd_addr1];
        end
        if (rd_en2) begin
            rd_a2 <= {mem_a1[rd_addr2], mem_a0[rd_addr2]};
            rd_b2 <= mem_b[rd_addr2];
        end
    end

    // MAC array models (not reset by rst; only cleared by mac_clr)
    logic [23:0] acc1 [2];
    logic [23:0] acc2 [2];

    always @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (mac_clr1) acc1[r] <= '0;
            else if (mac_en1) acc1[r] <= acc1[r] + 24'(mac_a1[r*8 +: 8]) * 24'(mac_b1);
            if (mac_clr2) acc2[r] <= '0;
            else if (mac_en2) acc2[r] <= acc2[r] + 24'(mac_a2[r*8 +: 8]) * 24'(mac_b2);
        end
    end

    assign mac_c1 = {acc1[1], acc1[0]};
    assign mac_c2 = {acc2[1], acc2[0]};

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Per-cycle recordings of DUT 1 (bit c = value in cycle c after start edge 0)
    logic [31:0] rec_rd_en, rec_mac_en, rec_clr, rec_done, rec_busy, rec_rv;
    logic [7:0]  rec_addr [32];
    logic [47:0] rec_res1;

    task automatic run1(input logic [7:0] base, input logic [31:0] hold_mask, input bit keep_start);
        base1  = base;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) start1 = 1'b0;
        rec_rd_en = '0; rec_mac_en = '0; rec_clr = '0;
        rec_done = '0; rec_busy = '0; rec_rv = '0;
        for (int c = 1; c < 32; c++) begin
            hold1 = hold_mask[c];
            #1;
            rec_rd_en[c]  = rd_en1;
            rec_mac_en[c] = mac_en1;
            rec_clr[c]    = mac_clr1;
            rec_done[c]   = done1;
            rec_busy[c]   = busy1;
            rec_rv[c]     = rv1;
            rec_addr[c]   = rd_addr1;
            if (c == 1) rec_res1 = result1;
            @(posedge clk);
            #1;
        end
        hold1 = 1'b0;
    endtask

    logic [31:0] rec2_rd_en, rec2_done;
    int          done_seen;

    initial begin
        rst = 1'b1;
        start1 = 1'b0; hold1 = 1'b0; base1 = '0;
        start2 = 1'b0; hold2 = 1'b0; base2 = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a0[i] = '0; mem_a1[i] = '0; mem_b[i] = '0;
        end
        #12;
        chk("reset_ctl", 64'({rd_en1, mac_en1, mac_clr1, busy1, done1, rv1}), 64'h0);
        chk("reset_ops", 64'({rd_addr1, mac_a1, mac_b1}), 64'h0);
        chk("reset_result", 64'(result1), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Job 1: base 0x10, A cols (1,2),(3,4),(5,6),(7,8), B all 1
        for (int j = 0; j < 4; j++) begin
            mem_a0[8'h10 + j] = 8'(2 * j + 1);
            mem_a1[8'h10 + j] = 8'(2 * j + 2);
            mem_b[8'h10 + j]  = 8'd1;
        end
        run1(8'h10, 32'h0, 1'b0);
        chk("j1_rd_en", 64'(rec_rd_en), 64'h3C);
        chk("j1_addr", 64'({rec_addr[5], rec_addr[4], rec_addr[3], rec_addr[2]}), 64'h13121110);
        chk("j1_mac_en", 64'(rec_mac_en), 64'h78);
        chk("j1_mac_clr", 64'(rec_clr), 64'h2);
        chk("j1_busy", 64'(rec_busy), 64'hFE);
        chk("j1_done", 64'(rec_done), 64'h100);
        chk("j1_rv", 64'(rec_rv[9:1]), 64'h180);
        chk("j1_result", 64'(result1), 64'h000014_000010);

        // Job 2: same data, hold in cycles 3 and 4
        run1(8'h10, 32'h18, 1'b0);
        chk("j2_rv_drop", 64'(rec_rv[11:1]), 64'h600);
        chk("j2_old_result", 64'(rec_res1), 64'h000014_000010);
        chk("j2_rd_en", 64'(rec_rd_en), 64'hE4);
        chk("j2_addr", 64'({rec_addr[7], rec_addr[6], rec_addr[5], rec_addr[2]}), 64'h13121110);
        chk("j2_mac_en", 64'(rec_mac_en), 64'h1C8);
        chk("j2_done", 64'(rec_done), 64'h400);
        chk("j2_result", 64'(result1), 64'h000014_000010);

        // Job 3: address wrap from 0xFE
        run1(8'hFE, 32'h0, 1'b0);
        chk("j3_addr", 64'({rec_addr[5], rec_addr[4], rec_addr[3], rec_addr[2]}), 64'h0100FFFE);

        // Job 4: start held high throughout
        run1(8'h10, 32'h0, 1'b1);
        chk("j4_clr_once", 64'(rec_clr[9:1]), 64'h1);
        chk("j4_clr_next", 64'(rec_clr[10]), 64'h1);
        chk("j4_done", 64'(rec_done[17:1]), 64'h10080);
        start1 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("j4_idle", 64'(busy1), 64'h0);

        // Job 5: reset in cycle 4, then a clean job with A=1, B=2
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", 64'({rd_en1, mac_en1, mac_clr1, busy1, done1, rv1}), 64'h0);
        chk("rst_mid_ops", 64'({rd_addr1, mac_a1, mac_b1}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) done_seen++;
        end
        chk("rst_no_done", 64'(done_seen), 64'h0);
        for (int j = 0; j < 4; j++) begin
            mem_a0[8'h10 + j] = 8'd1;
            mem_a1[8'h10 + j] = 8'd1;
            mem_b[8'h10 + j]  = 8'd2;
        end
        run1(8'h10, 32'h0, 1'b0);
        chk("j5_done", 64'(rec_done), 64'h100);
        chk("j5_result", 64'(result1), 64'h000008_000008);

        // Job 6: COLS=1 instance, A=(255,255), B=255
        mem_a0[8'h20] = 8'hFF;
        mem_a1[8'h20] = 8'hFF;
        mem_b[8'h20]  = 8'hFF;
        base2  = 8'h20;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        rec2_rd_en = '0;
        rec2_done  = '0;
        for (int c = 1; c < 12; c++) begin
            #1;
            rec2_rd_en[c] = rd_en2;
            rec2_done[c]  = done2;
            @(posedge clk);
            #1;
        end
        chk("c1_rd_en", 64'(rec2_rd_en), 64'h4);
        chk("c1_done", 64'(rec2_done), 64'h20);
        chk("c1_result", 64'(result2), 64'h00FE01_00FE01);
        chk("c1_rv", 64'(rv2), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
